// File: rtl/ppdu_encoder_ctrl.sv
// ppdu_encoder_ctrl: emits the SIGNAL word then a length-derived count of DATA words towards the encoder
module ppdu_encoder_ctrl #(
  parameter int WIDTH = 24
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [15:0]      s_cfg_tdata,
  input  logic             s_cfg_tvalid,
  output logic             s_cfg_tready,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic [3:0]       m_axis_tuser,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             err
);
  localparam logic [3:0] RATE_6M = 4'b1011;
  localparam logic [15:0] W16 = 16'(WIDTH);
  typedef enum logic [1:0] {IDLE, SIG, DATA} state_t;
  state_t state;
  logic [3:0] rate;
  logic [15:0] rem;
  logic [3:0] cfg_rate;
  logic [11:0] cfg_len;
  logic [WIDTH-1:0] sig_word;
  logic cfg_hs, up_hs, out_hs, last_word;
  assign cfg_rate = s_cfg_tdata[15:12];
  assign cfg_len = s_cfg_tdata[11:0];
  assign sig_word = {6'd0, ^{cfg_len, cfg_rate}, cfg_len, 1'b0, cfg_rate};
  assign cfg_hs = s_cfg_tvalid & s_cfg_tready;
  assign out_hs = m_axis_tvalid & m_axis_tready;
  assign up_hs = s_axis_tvalid & s_axis_tready;
  assign last_word = rem <= W16;
  // once the final word sits in the output register no further upstream word may enter
  assign s_axis_tready = (state == DATA) & ~m_axis_tlast & (m_axis_tready | ~m_axis_tvalid);
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      rate <= '0;
      rem <= '0;
      m_axis_tdata <= '0;
      m_axis_tuser <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      s_cfg_tready <= 1'b1;
      busy <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= cfg_hs & (cfg_len == 12'd0);
      case (state)
        IDLE: if (cfg_hs && cfg_len != 12'd0) begin
          rate <= cfg_rate;
          rem <= 16'd22 + {1'b0, cfg_len, 3'b000};
          m_axis_tdata <= sig_word;
          m_axis_tuser <= RATE_6M;
          m_axis_tlast <= 1'b0;
          m_axis_tvalid <= 1'b1;
          s_cfg_tready <= 1'b0;
          busy <= 1'b1;
          state <= SIG;
        end
        SIG: if (out_hs) begin
          m_axis_tvalid <= 1'b0;
          state <= DATA;
        end
        DATA: if (up_hs) begin
          m_axis_tdata <= s_axis_tdata;
          m_axis_tuser <= rate;
          m_axis_tlast <= last_word;
          m_axis_tvalid <= 1'b1;
          rem <= last_word ? 16'd0 : rem - W16;
        end else if (out_hs) begin
          m_axis_tvalid <= 1'b0;
          if (m_axis_tlast) begin
            m_axis_tlast <= 1'b0;
            s_cfg_tready <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ppdu_encoder_ctrl.sv
// tb_ppdu_encoder_ctrl: random PPDU traffic against a queue-based reference of the expected output stream
module tb_ppdu_encoder_ctrl;
  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  logic [15:0] s_cfg_tdata = '0;
  logic s_cfg_tvalid = 1'b0;
  logic s_cfg_tready;
  logic [23:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic [23:0] m_axis_tdata;
  logic [3:0] m_axis_tuser;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b1;
  logic m_axis_tlast;
  logic busy, err;

  ppdu_encoder_ctrl #(.WIDTH(24)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_cfg_tdata(s_cfg_tdata), .s_cfg_tvalid(s_cfg_tvalid), .s_cfg_tready(s_cfg_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy), .err(err)
  );

  always #5 aclk = ~aclk;

  typedef struct {logic [23:0] d; logic [3:0] u; logic l; bit sig;} ent_t;
  ent_t exp_q[$];
  logic [23:0] up_q[$];
  logic [15:0] cfg_q[$];
  ent_t mon_e;
  int checks = 0, failures = 0;
  bit bp = 0, gap = 0, model_busy = 0, exp_err = 0, stall_prev = 0, up_hs = 0, cfg_hs = 0;
  logic [23:0] prev_d, last_sig;
  logic [3:0] prev_u;
  logic prev_l;
  int ndata = 0, last_ndata = 0, err_cnt = 0;
  logic [3:0] rates [8] = '{4'hB, 4'hF, 4'hA, 4'hE, 4'h9, 4'hD, 4'h8, 4'hC};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [23:0] sig_of(input logic [3:0] r, input logic [11:0] l);
    int v;
    v = int'(r) + int'(l) * 32 + (($countones(r) + $countones(l)) % 2) * 131072;
    return v[23:0];
  endfunction

  task automatic ppdu(input logic [3:0] r, input logic [11:0] l);
    int n;
    ent_t e;
    cfg_q.push_back({r, l});
    if (l == 12'd0) return;
    e.d = sig_of(r, l); e.u = 4'hB; e.l = 1'b0; e.sig = 1'b1;
    exp_q.push_back(e);
    n = (22 + 8 * int'(l) + 23) / 24;
    for (int i = 0; i < n; i++) begin
      e.d = 24'($urandom); e.u = r; e.l = (i == n - 1); e.sig = 1'b0;
      exp_q.push_back(e);
      up_q.push_back(e.d);
    end
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge aclk); #2;
      if (exp_q.size() == 0 && cfg_q.size() == 0 && !model_busy) break;
    end
    check("drain", i < budget, 1);
  endtask

  initial forever begin
    @(posedge aclk); #1;
    if (up_hs && up_q.size() > 0) up_q.delete(0);
    if (cfg_hs && cfg_q.size() > 0) cfg_q.delete(0);
    up_hs = 0;
    cfg_hs = 0;
    s_axis_tvalid = aresetn && up_q.size() > 0 && (!gap || $urandom_range(0, 2) != 0);
    s_axis_tdata = up_q.size() > 0 ? up_q[0] : 24'h0;
    s_cfg_tvalid = aresetn && cfg_q.size() > 0;
    s_cfg_tdata = cfg_q.size() > 0 ? cfg_q[0] : 16'h0;
    m_axis_tready = !bp || $urandom_range(0, 1) == 1;
  end

  always @(negedge aclk) if (aresetn) begin
    check("busy", busy, model_busy);
    check("err", err, exp_err);
    check("cfg_rdy", s_cfg_tready, !model_busy);
    if (err) err_cnt++;
    if (stall_prev) begin
      check("hold_v", m_axis_tvalid, 1);
      check("hold_d", m_axis_tdata, prev_d);
      check("hold_u", m_axis_tuser, prev_u);
      check("hold_l", m_axis_tlast, prev_l);
    end
    if (m_axis_tvalid && !m_axis_tready) check("stall_srdy", s_axis_tready, 0);
    stall_prev = m_axis_tvalid && !m_axis_tready;
    prev_d = m_axis_tdata; prev_u = m_axis_tuser; prev_l = m_axis_tlast;
    up_hs = s_axis_tvalid && s_axis_tready;
    cfg_hs = s_cfg_tvalid && s_cfg_tready;
    exp_err = cfg_hs && s_cfg_tdata[11:0] == 12'd0;
    if (cfg_hs && s_cfg_tdata[11:0] != 12'd0) model_busy = 1;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) check("spurious", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("data", m_axis_tdata, mon_e.d);
        check("tuser", m_axis_tuser, mon_e.u);
        check("tlast", m_axis_tlast, mon_e.l);
        if (mon_e.sig) begin last_sig = m_axis_tdata; ndata = 0; end
        else ndata++;
        if (mon_e.l) begin model_busy = 0; last_ndata = ndata; end
      end
    end
  end

  initial begin
    int i, e0;
    #1 aresetn = 1'b0;
    #2;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_srdy", s_axis_tready, 0);
    check("rst_cfgrdy", s_cfg_tready, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    #19 aresetn = 1'b1;
    last_sig = '0;
    ppdu(4'hD, 12'd100);
    drain(2000);
    check("sig_vec", last_sig, 24'h000c8d);
    check("n_len100", last_ndata, 35);
    ppdu(4'hF, 12'd1);
    drain(200);
    check("n_len1", last_ndata, 2);
    ppdu(4'hC, 12'd4095);
    drain(5000);
    check("n_len4095", last_ndata, 1366);
    e0 = err_cnt;
    ppdu(4'h9, 12'd0);
    drain(200);
    repeat (3) @(negedge aclk);
    check("err_pulses", err_cnt - e0, 1);
    ppdu(4'hA, 12'd5);
    ppdu(4'h8, 12'd7);
    drain(500);
    bp = 1; gap = 1;
    for (int k = 0; k < 25; k++)
      ppdu(rates[$urandom_range(0, 7)], $urandom_range(0, 9) == 0 ? 12'd0 : 12'($urandom_range(1, 150)));
    drain(30000);
    bp = 0; gap = 0;
    ndata = 0;
    ppdu(4'hD, 12'd100);
    for (i = 0; i < 2000 && ndata < 10; i++) begin @(negedge aclk); #2; end
    check("rst_wait", ndata >= 10, 1);
    @(posedge aclk); #2;
    aresetn = 1'b0;
    exp_q.delete(); up_q.delete(); cfg_q.delete();
    s_axis_tvalid = 0; s_cfg_tvalid = 0;
    up_hs = 0; cfg_hs = 0; model_busy = 0; exp_err = 0; stall_prev = 0;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tlast", m_axis_tlast, 0);
    check("mid_rst_tdata", m_axis_tdata, 0);
    check("mid_rst_srdy", s_axis_tready, 0);
    check("mid_rst_cfgrdy", s_cfg_tready, 1);
    @(negedge aclk); #2 aresetn = 1'b1;
    last_sig = '0;
    ppdu(4'hD, 12'd100);
    drain(2000);
    check("sig_after_rst", last_sig, 24'h000c8d);
    check("n_after_rst", last_ndata, 35);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
